// File: rtl/dbr_pkg.sv
// rtl/dbr_pkg.sv - shared address map, bus encodings and STATUS layout for data_bus_responder
package dbr_pkg;

    localparam logic [15:0] ADDR_RAM_BASE = 16'h0000;
    localparam logic [15:0] ADDR_REG_BASE = 16'hF000;

    localparam logic [15:0] OFS_CYCLE  = 16'h0000;
    localparam logic [15:0] OFS_TXDATA = 16'h0001;
    localparam logic [15:0] OFS_STATUS = 16'h0002;
    localparam logic [15:0] OFS_DROPS  = 16'h0003;

    localparam logic [15:0] ADDR_CYCLE  = ADDR_REG_BASE + OFS_CYCLE;
    localparam logic [15:0] ADDR_TXDATA = ADDR_REG_BASE + OFS_TXDATA;
    localparam logic [15:0] ADDR_STATUS = ADDR_REG_BASE + OFS_STATUS;
    localparam logic [15:0] ADDR_DROPS  = ADDR_REG_BASE + OFS_DROPS;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_W   = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_CYCLE,
        REG_TXDATA,
        REG_STATUS,
        REG_DROPS
    } dbr_region_e;

    // RAM window size is a parameter of the top, so the caller resolves it.
    function automatic dbr_region_e dbr_decode(input logic [15:0] addr, input logic ram_hit);
        dbr_region_e r;
        r = REG_NONE;
        if (ram_hit) begin
            r = REG_RAM;
        end else begin
            case (addr)
                ADDR_CYCLE:  r = REG_CYCLE;
                ADDR_TXDATA: r = REG_TXDATA;
                ADDR_STATUS: r = REG_STATUS;
                ADDR_DROPS:  r = REG_DROPS;
                default:     r = REG_NONE;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] dbr_status_word(input logic empty, input logic full,
                                                    input logic [STATUS_COUNT_W-1:0] count);
        logic [31:0] s;
        s = '0;
        s[STATUS_EMPTY_BIT] = empty;
        s[STATUS_FULL_BIT]  = full;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/dbr_tx_fifo.sv
// rtl/dbr_tx_fifo.sv - byte FIFO feeding the TX stream, reports drops on overflow
//   i_clk, i_reset_n         clock, async active-low reset
//   push, push_data[7:0]     write request and byte
//   pop                      read request (ignored when empty)
//   head_data[7:0]           head entry, 0 while empty
//   full, empty, count       occupancy
//   drop                     push refused this cycle (full, no simultaneous pop)
module dbr_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Storage is not reset; masking keeps the output at 0 while empty or in reset.
    assign head_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - CPU data-bus slave: RAM, TX byte FIFO, CYCLE/STATUS/DROPS registers
//   optional: DATA_BUS_RESPONDER_CYCLE_COUNTER_EN enables the CYCLE counter at 0xF000
//   i_clk, i_reset_n                 clock, async active-low reset
//   i_address[15:0], i_rw, i_wdata   bus request (write every cycle i_rw=1)
//   o_rdata[31:0]                    combinational read data
//   o_tx_valid, o_tx_data, i_tx_ready  TX byte stream
module data_bus_responder
    import dbr_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_address,
    input  logic        i_rw,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);

    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram [RAM_WORDS];
    logic [31:0]    addr_ext;
    logic           ram_hit;
    dbr_region_e    region;
    logic           wr_en;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_drop;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]    drops;

    assign addr_ext = {16'h0000, i_address} - {16'h0000, ADDR_RAM_BASE};
    assign ram_hit  = (addr_ext < 32'(RAM_WORDS));
    assign region   = dbr_decode(i_address, ram_hit);
    assign wr_en    = (i_rw == RW_WRITE);

    always_ff @(posedge i_clk) begin
        if (wr_en && region == REG_RAM) begin
            ram[addr_ext[RAM_AW-1:0]] <= i_wdata;
        end
    end

    assign fifo_push = wr_en && (region == REG_TXDATA);
    assign fifo_pop  = o_tx_valid && i_tx_ready;

    dbr_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (fifo_push),
        .push_data (i_wdata[7:0]),
        .pop       (fifo_pop),
        .head_data (o_tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    assign o_tx_valid = !fifo_empty;

    // A clear and a drop can coincide only in theory (one address per cycle),
    // but the clear is given priority regardless.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drops <= '0;
        end else if (wr_en && region == REG_DROPS) begin
            drops <= '0;
        end else if (fifo_drop && drops != 32'hFFFF_FFFF) begin
            drops <= drops + 32'd1;
        end
    end

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        o_rdata = '0;
        case (region)
            REG_RAM:    o_rdata = ram[addr_ext[RAM_AW-1:0]];
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
            REG_CYCLE:  o_rdata = cycle_cnt;
`endif
            REG_STATUS: o_rdata = dbr_status_word(fifo_empty, fifo_full,
                                                  STATUS_COUNT_W'(fifo_count));
            REG_DROPS:  o_rdata = drops;
            default:    o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - randomized scoreboard bench for data_bus_responder
module tb_data_bus_responder;

    localparam int DEPTH     = 8;
    localparam int RAM_WORDS = 256;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_address = 16'h1234;
    logic        i_rw = 1'b0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_ram [int];
    logic [7:0]  mq [$];
    logic [7:0]  sbq [$];
    logic [31:0] m_drops = 0;
    logic [31:0] m_cycle = 0;

    data_bus_responder #(.RAM_AW(8), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_address  (i_address),
        .i_rw       (i_rw),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every observed handshake consumes the oldest accepted byte.
    always @(negedge i_clk) begin
        if (i_reset_n && o_tx_valid && i_tx_ready) begin
            if (sbq.size() == 0) begin
                chk("tx_unexpected_byte", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_data", {24'h0, o_tx_data}, {24'h0, sbq.pop_front()});
            end
        end
    end

    function automatic bit model_read(input logic [15:0] a, output logic [31:0] v);
        int n;
        n = mq.size();
        v = '0;
        if (int'(a) < RAM_WORDS) begin
            if (!m_ram.exists(int'(a))) return 1'b0;
            v = m_ram[int'(a)];
            return 1'b1;
        end
        case (a)
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
            16'hF000: v = m_cycle;
`endif
            16'hF002: v = {16'h0, 8'(n), 6'h0, (n == DEPTH), (n == 0)};
            16'hF003: v = m_drops;
            default:  v = '0;
        endcase
        return 1'b1;
    endfunction

    function automatic void model_step(input logic [15:0] a, input logic rw,
                                       input logic [31:0] wd, input logic rdy);
        int  pre;
        bit  popped;
        pre = mq.size();
        popped = (pre > 0) && rdy;
        if (popped) void'(mq.pop_front());
        if (rw) begin
            if (int'(a) < RAM_WORDS) begin
                m_ram[int'(a)] = wd;
            end else if (a == 16'hF001) begin
                if (pre == DEPTH && !popped) begin
                    if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
                end else begin
                    mq.push_back(wd[7:0]);
                    sbq.push_back(wd[7:0]);
                end
            end else if (a == 16'hF003) begin
                m_drops = 0;
            end
        end
        m_cycle = m_cycle + 1;
    endfunction

    task automatic op(input logic [15:0] a, input logic rw, input logic [31:0] wd, input logic rdy);
        logic [31:0] ev;
        bit known;
        i_address = a; i_rw = rw; i_wdata = wd; i_tx_ready = rdy;
        @(negedge i_clk);
        known = model_read(a, ev);
        if (known) chk($sformatf("rdata@%h", a), o_rdata, ev);
        chk("tx_valid", {31'h0, o_tx_valid}, {31'h0, (mq.size() != 0)});
        @(posedge i_clk);
        model_step(a, rw, wd, rdy);
        #1;
        i_rw = 1'b0;
    endtask

    task automatic rd_const(input string nm, input logic [15:0] a, input logic rdy, input logic [31:0] exp);
        i_address = a; i_rw = 1'b0; i_wdata = '0; i_tx_ready = rdy;
        @(negedge i_clk);
        chk(nm, o_rdata, exp);
        @(posedge i_clk);
        model_step(a, 1'b0, '0, rdy);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (mq.size() != 0 && budget < 64) begin
            op(16'h1234, 1'b0, '0, 1'b1);
            budget++;
        end
        chk("drain_timeout", {31'h0, (mq.size() != 0)}, 32'h0);
        chk("scoreboard_empty", sbq.size(), 32'h0);
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0;
        i_rw = 1'b0;
        mq.delete();
        sbq.delete();
        m_drops = 0;
        m_cycle = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        apply_reset();

        // Reset state and CYCLE after 10 clocks.
        chk("reset_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, o_tx_data}, 32'h0);
        for (int i = 0; i < 10; i++) op(16'h1234, 1'b0, '0, 1'b0);
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
        rd_const("cycle_after_10", 16'hF000, 1'b0, 32'd10);
`else
        rd_const("cycle_after_10", 16'hF000, 1'b0, 32'd0);
`endif
        rd_const("reset_status", 16'hF002, 1'b0, 32'h0000_0001);
        rd_const("reset_drops", 16'hF003, 1'b0, 32'h0);

        // RAM write/read, same-cycle read returns prior contents.
        op(16'h0010, 1'b1, 32'h1111_1111, 1'b0);
        op(16'h0010, 1'b1, 32'hDEAD_BEEF, 1'b0);
        rd_const("ram_readback", 16'h0010, 1'b0, 32'hDEAD_BEEF);

        // Unmapped / write-only reads and ignored writes.
        rd_const("unmapped_read", 16'h1234, 1'b0, 32'h0);
        rd_const("txdata_read", 16'hF001, 1'b0, 32'h0);
        op(16'h1234, 1'b1, 32'hCAFE_F00D, 1'b0);
        op(16'h0100, 1'b1, 32'h1234_5678, 1'b0);
        op(16'hF002, 1'b1, 32'hFFFF_FFFF, 1'b0);
        rd_const("above_ram_read", 16'h0100, 1'b0, 32'h0);
        rd_const("ram_intact", 16'h0010, 1'b0, 32'hDEAD_BEEF);
        rd_const("status_intact", 16'hF002, 1'b0, 32'h0000_0001);

        // Overflow with consumer stalled.
        for (int b = 8'h41; b <= 8'h48; b++) op(16'hF001, 1'b1, 32'hABCD_EF00 | 32'(b), 1'b0);
        rd_const("status_full", 16'hF002, 1'b0, 32'h0000_0802);
        op(16'hF001, 1'b1, 32'h49, 1'b0);
        rd_const("drops_one", 16'hF003, 1'b0, 32'h1);
        rd_const("status_still_full", 16'hF002, 1'b0, 32'h0000_0802);
        drain();
        rd_const("status_drained", 16'hF002, 1'b0, 32'h0000_0001);
        op(16'hF003, 1'b1, 32'h0, 1'b0);
        rd_const("drops_cleared", 16'hF003, 1'b0, 32'h0);

        // Push while full with a simultaneous pop.
        for (int b = 1; b <= 8; b++) op(16'hF001, 1'b1, 32'(b), 1'b0);
        op(16'hF001, 1'b1, 32'h55, 1'b1);
        rd_const("status_push_pop_full", 16'hF002, 1'b0, 32'h0000_0802);
        rd_const("drops_push_pop_full", 16'hF003, 1'b0, 32'h0);
        drain();

        // Reset in the middle of a queued stream.
        for (int b = 0; b < 3; b++) op(16'hF001, 1'b1, 32'h60 + 32'(b), 1'b0);
        @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("midreset_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        chk("midreset_tx_data", {24'h0, o_tx_data}, 32'h0);
        apply_reset();
        rd_const("postreset_status", 16'hF002, 1'b1, 32'h0000_0001);
        rd_const("postreset_drops", 16'hF003, 1'b1, 32'h0);

        // Randomized traffic against the reference model.
        for (int ph = 0; ph < 4; ph++) begin
            int pct;
            pct = (ph == 0) ? 10 : (ph == 1) ? 60 : (ph == 2) ? 25 : 90;
            for (int n = 0; n < 100; n++) begin
                logic [15:0] a;
                logic        rw;
                int          sel;
                sel = $urandom_range(0, 11);
                case (sel)
                    0, 1, 2, 3: a = 16'($urandom_range(0, 15));
                    4:          a = 16'($urandom_range(16'h0100, 16'h01FF));
                    5:          a = 16'hF000;
                    6, 7, 8:    a = 16'hF001;
                    9:          a = 16'hF002;
                    10:         a = 16'hF003;
                    default:    a = 16'h1234;
                endcase
                rw = ($urandom_range(0, 99) < 60);
                if (a == 16'hF003) rw = ($urandom_range(0, 9) == 0);
                op(a, rw, $urandom, ($urandom_range(0, 99) < pct));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
